pll_lock_monitor: RTL and testbench
===================================

# pll_lock_monitor

Supervises the PLL lock output from the reference-clock side and drives the PLL reset input: a PLL reset/relock controller. Runs on the reference clock, synchronizes the asynchronous `locked` signal, and requires lock to stay stable before declaring the clock good. On lock loss it re-issues a timed PLL reset. After repeated failed lock attempts it latches a fault. It complements the clock/reset generator by taking the PLL reset decision away from a raw inverted system reset.

## Interface
- `RST_CYCLES`, default 16: PLL reset pulse length in cycles, ≥1.
- `LOCK_TIMEOUT`, default 4096: number of cycles to wait for lock per attempt, ≥1.
- `STABLE_CYCLES`, default 256: number of continuous locked cycles required before `lock_ok_o` asserts, ≥1.
- `MAX_RETRY`, default 3: number of consecutive failed attempts before fault, ≥1.
- `clk_i` input 1: reference clock; the only clock.
- `rstn_i` input 1: reset, asynchronous and active-low.
- `locked_i` input 1: PLL lock indicator; asynchronous to `clk_i`.
- `clr_fault_i` input 1: single-cycle pulse that clears the fault; ignored outside FAULT.
- `pll_rst_o` output 1: active-high reset to the PLL.
- `lock_ok_o` output 1: the PLL clock is qualified stable.
- `fault_o` output 1: the retry limit is exhausted.
- `loss_cnt_o` output 8: saturating lock-loss count (present only with `PLL_LOCK_MON_STATS_EN`).

## Operation
- `locked_i` passes through a 2-flop synchronizer, producing `locked_s`. The FSM sees only `locked_s`.
- Cycle counter `cnt`, width `$clog2` of the maximum of the three cycle parameters. Retry counter `retry`, width `$clog2(MAX_RETRY+1)`.
- States are RST, WAIT, STAB, OK, FAULT.
- **RST**
  - `pll_rst_o`=1.
  - Moves to WAIT when `cnt`==`RST_CYCLES`-1; `cnt` clears on the transition.
- **WAIT**
  - `pll_rst_o`=0.
  - If `locked_s`=1, move to STAB with `cnt`=0.
  - Otherwise, when `cnt`==`LOCK_TIMEOUT`-1, the attempt fails.
- **STAB**
  - If `locked_s`=0 on any cycle, the attempt fails.
  - When `cnt`==`STABLE_CYCLES`-1 with `locked_s`=1, move to OK and set `retry`=0.
- **Failed attempt**
  - `retry`+1.
  - If the new value equals `MAX_RETRY`, move to FAULT; otherwise move to RST with `cnt`=0.
- **OK**
  - `lock_ok_o`=1.
  - If `locked_s`=0, move to RST, set `retry`=0, and increment `loss_cnt` (saturating at 255).
- **FAULT**
  - `pll_rst_o`=1 and `fault_o`=1, held.
  - `clr_fault_i`=1 moves to RST with `retry`=0 and `cnt`=0.
- All outputs are registered and decoded from the state register, so they are glitch-free.
- Simultaneous events: a lock event and a timeout in the same WAIT cycle resolve as lock (lock wins).

## Timing
- **Reset values** (applied immediately on `rstn_i` low, including mid-operation):
  - state=RST, `cnt`=0, `retry`=0, synchronizer flops=0.
  - `pll_rst_o`=1, `lock_ok_o`=0, `fault_o`=0, `loss_cnt_o`=0.
- Reset release: `pll_rst_o` falls on the `RST_CYCLES`-th rising edge after `rstn_i` deasserts.
- Synchronizer latency: the FSM reacts on the 3rd edge counting from the edge that first samples the new `locked_i` value (call that edge e0; the FSM acts at e2).
- Lock qualification: with `locked_i` first sampled high at e0 while in WAIT, `lock_ok_o` is high after edge e0+`STABLE_CYCLES`+2.
- Lock loss in OK: with `locked_i` first sampled low at e0, both `lock_ok_o`=0 and `pll_rst_o`=1 after edge e2.
- A `locked_i` pulse shorter than one `clk_i` period may be missed. This is acceptable.

## Configuration
- `PLL_LOCK_MON_STATS_EN` defined:
  - The `loss_cnt_o` port and its 8-bit saturating counter exist.
  - The counter is cleared only by `rstn_i`.
- `PLL_LOCK_MON_STATS_EN` undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

## Structure
- Shared package `pll_mon_pkg` holds:
  - the `pll_mon_state_e` enum (RST, WAIT, STAB, OK, FAULT, 3-bit);
  - the `LOSS_CNT_W`=8 constant.
- One sub-module, `sync_2ff`: a generic 2-flop bit synchronizer with asynchronous active-low reset. It is reusable elsewhere.

## Test plan
All scenarios use `RST_CYCLES`=4, `LOCK_TIMEOUT`=32, `STABLE_CYCLES`=8, `MAX_RETRY`=2.
- **Clean lock:** release `rstn_i`; raise `locked_i` 10 cycles after `pll_rst_o` falls → `pll_rst_o` high for exactly 4 cycles; `lock_ok_o` rises 10 edges after `locked_i` is sampled high; `fault_o`=0.
- **Timeout to fault:** hold `locked_i`=0 → two rounds of 4-cycle RST plus 32-cycle WAIT, then `fault_o`=1 and `pll_rst_o`=1 held; pulse `clr_fault_i` → `fault_o`=0 next cycle and a new RST pulse of 4 cycles.
- **Stabilization glitch:** drop `locked_i` for 2 cycles at STAB cycle 5 → `pll_rst_o` pulses again; `lock_ok_o` never asserts; `retry`=1.
- **Loss in OK:** drop `locked_i` → `lock_ok_o`=0 and `pll_rst_o`=1 two edges after the low sample; relock succeeds; `loss_cnt_o`=1 with the macro defined.
- **Async reset mid-STAB:** assert `rstn_i` → all outputs go to reset values without a clock edge.
- **Simultaneous lock and timeout:** `locked_s` rises in the WAIT cycle where `cnt`=31 → state goes to STAB; `retry` is unchanged.

Source files
------------

// File: rtl/pll_mon_pkg.sv
// Shared types and constants for the PLL lock monitor.
package pll_mon_pkg;

    localparam int LOSS_CNT_W = 8;

    typedef enum logic [2:0] {
        RST   = 3'd0,
        WAIT  = 3'd1,
        STAB  = 3'd2,
        OK    = 3'd3,
        FAULT = 3'd4
    } pll_mon_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit.
module sync_2ff (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_monitor.sv
// PLL reset/relock controller: times PLL reset, qualifies lock, retries, latches fault.
// Define PLL_LOCK_MON_STATS_EN to add the saturating lock-loss counter port loss_cnt_o.
module pll_lock_monitor
    import pll_mon_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRY     = 3
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic locked_i,
    input  logic clr_fault_i,
    output logic pll_rst_o,
    output logic lock_ok_o,
    output logic fault_o
`ifdef PLL_LOCK_MON_STATS_EN
    ,
    output logic [LOSS_CNT_W-1:0] loss_cnt_o
`endif
);

    localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   WAIT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

    pll_mon_state_e     state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [RETRY_W-1:0] retry_inc;
    logic               attempt_fail;
    logic               locked_s;
    logic               pll_rst_q, lock_ok_q, fault_q;

    sync_2ff u_sync (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (locked_i),
        .q_o    (locked_s)
    );

    assign retry_inc = retry_q + 1'b1;

    // Lock is checked before the timeout in WAIT, so a coincident lock wins.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        retry_d      = retry_q;
        attempt_fail = 1'b0;
        unique case (state_q)
            RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (locked_s) begin
                    state_d = STAB;
                    cnt_d   = '0;
                end else if (cnt_q == WAIT_LAST) begin
                    attempt_fail = 1'b1;
                end
            end
            STAB: begin
                if (!locked_s) begin
                    attempt_fail = 1'b1;
                end else if (cnt_q == STAB_LAST) begin
                    state_d = OK;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            OK: begin
                cnt_d = '0;
                if (!locked_s) begin
                    state_d = RST;
                    retry_d = '0;
                end
            end
            FAULT: begin
                cnt_d = '0;
                if (clr_fault_i) begin
                    state_d = RST;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = RST;
                cnt_d   = '0;
                retry_d = '0;
            end
        endcase

        if (attempt_fail) begin
            retry_d = retry_inc;
            cnt_d   = '0;
            state_d = (retry_inc == RETRY_LIM) ? FAULT : RST;
        end
    end

    // Outputs are registered from the next state so they change with the state register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= RST;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            lock_ok_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pll_rst_q <= (state_d == RST) || (state_d == FAULT);
            lock_ok_q <= (state_d == OK);
            fault_q   <= (state_d == FAULT);
        end
    end

    assign pll_rst_o = pll_rst_q;
    assign lock_ok_o = lock_ok_q;
    assign fault_o   = fault_q;

`ifdef PLL_LOCK_MON_STATS_EN
    logic [LOSS_CNT_W-1:0] loss_cnt_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            loss_cnt_q <= '0;
        end else if ((state_q == OK) && !locked_s && (loss_cnt_q != '1)) begin
            loss_cnt_q <= loss_cnt_q + 1'b1;
        end
    end

    assign loss_cnt_o = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Self-checking bench for pll_lock_monitor: directed vectors plus randomized run against a timestamp model.
module tb_pll_lock_monitor;

    localparam int RC = 4;
    localparam int TO = 32;
    localparam int SC = 8;
    localparam int MR = 2;

    localparam int PH_RST   = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_STAB  = 2;
    localparam int PH_OK    = 3;
    localparam int PH_FAULT = 4;

    typedef struct {
        logic       locked;
        logic       clr;
        int         n;
        logic [2:0] exp;
    } vec_t;

    logic clk_i       = 1'b0;
    logic rstn_i      = 1'b0;
    logic locked_i    = 1'b0;
    logic clr_fault_i = 1'b0;
    logic pll_rst_o, lock_ok_o, fault_o;
`ifdef PLL_LOCK_MON_STATS_EN
    logic [7:0] loss_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    bit modelOn = 1'b0;
    int mPh, mCyc, mStart, mTries, mLosses;
    bit mHist0, mHist1;

    pll_lock_monitor #(
        .RST_CYCLES    (RC),
        .LOCK_TIMEOUT  (TO),
        .STABLE_CYCLES (SC),
        .MAX_RETRY     (MR)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .locked_i    (locked_i),
        .clr_fault_i (clr_fault_i),
        .pll_rst_o   (pll_rst_o),
        .lock_ok_o   (lock_ok_o),
        .fault_o     (fault_o)
`ifdef PLL_LOCK_MON_STATS_EN
        ,
        .loss_cnt_o  (loss_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic modelEnter(input int ph);
        mPh    = ph;
        mStart = mCyc;
    endtask

    task automatic modelFail();
        mTries++;
        modelEnter((mTries == MR) ? PH_FAULT : PH_RST);
    endtask

    task automatic modelReset();
        mPh     = PH_RST;
        mStart  = mCyc;
        mTries  = 0;
        mLosses = 0;
        mHist0  = 1'b0;
        mHist1  = 1'b0;
    endtask

    // Elapsed = full cycles already spent in the phase before this edge.
    task automatic modelStep();
        bit ls;
        int el;
        ls     = mHist1;
        mHist1 = mHist0;
        mHist0 = locked_i;
        mCyc++;
        el = mCyc - mStart - 1;
        case (mPh)
            PH_RST:   if (el == RC - 1) modelEnter(PH_WAIT);
            PH_WAIT:  if (ls) modelEnter(PH_STAB); else if (el == TO - 1) modelFail();
            PH_STAB:  if (!ls) modelFail(); else if (el == SC - 1) begin modelEnter(PH_OK); mTries = 0; end
            PH_OK:    if (!ls) begin
                          modelEnter(PH_RST);
                          mTries  = 0;
                          mLosses = (mLosses < 255) ? mLosses + 1 : 255;
                      end
            default:  if (clr_fault_i) begin modelEnter(PH_RST); mTries = 0; end
        endcase
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (modelOn && rstn_i) modelStep();
        @(negedge clk_i);
    endtask

    task automatic applyStimulus(input logic lk, input logic clr, input int n,
                                 input logic [2:0] exp, input string name);
        locked_i    = lk;
        clr_fault_i = clr;
        for (int i = 0; i < n; i++) begin
            tick();
            checkOutput($sformatf("%s[%0d] rst/ok/fault", name, i),
                        {5'b0, pll_rst_o, lock_ok_o, fault_o}, {5'b0, exp});
        end
    endtask

    task automatic applyReset(input logic lk);
        @(negedge clk_i);
        rstn_i      = 1'b0;
        locked_i    = lk;
        clr_fault_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checkOutput("reset_outputs", {5'b0, pll_rst_o, lock_ok_o, fault_o}, 8'b100);
`ifdef PLL_LOCK_MON_STATS_EN
        checkOutput("reset_loss_cnt", loss_cnt_o, 8'd0);
`endif
        rstn_i = 1'b1;
        modelReset();
    endtask

    task automatic waitLock(input string name);
        int n;
        n = 0;
        while (!lock_ok_o && n < 60) begin
            tick();
            n++;
        end
        checkOutput(name, {7'b0, lock_ok_o}, 8'd1);
    endtask

    initial begin
        vec_t tbl[4];
        int   hold;

        tbl[0] = '{1'b0, 1'b0, 3,  3'b100};
        tbl[1] = '{1'b0, 1'b0, 10, 3'b000};
        tbl[2] = '{1'b1, 1'b0, 10, 3'b000};
        tbl[3] = '{1'b1, 1'b0, 5,  3'b010};

        // Clean lock: lock sampled on edge 14, qualified on edge 24.
        applyReset(1'b0);
        for (int i = 0; i < 4; i++)
            applyStimulus(tbl[i].locked, tbl[i].clr, tbl[i].n, tbl[i].exp, $sformatf("clean%0d", i));

        // Loss in OK, relock, then asynchronous reset while qualified.
        applyStimulus(1'b0, 1'b0, 2, 3'b010, "loss_hold");
        applyStimulus(1'b0, 1'b0, 1, 3'b100, "loss_drop");
        applyStimulus(1'b1, 1'b0, 3, 3'b100, "loss_rst");
        applyStimulus(1'b1, 1'b0, 1, 3'b000, "loss_wait");
        applyStimulus(1'b1, 1'b0, 8, 3'b000, "loss_stab");
        applyStimulus(1'b1, 1'b0, 1, 3'b010, "loss_relock");
`ifdef PLL_LOCK_MON_STATS_EN
        checkOutput("loss_cnt_one", loss_cnt_o, 8'd1);
`endif
        #2 rstn_i = 1'b0;
        #1 checkOutput("async_ok", {5'b0, pll_rst_o, lock_ok_o, fault_o}, 8'b100);
`ifdef PLL_LOCK_MON_STATS_EN
        checkOutput("async_ok_loss", loss_cnt_o, 8'd0);
`endif

        // Timeout to fault, then clear.
        applyReset(1'b0);
        applyStimulus(1'b0, 1'b0, 3,  3'b100, "to_rst1");
        applyStimulus(1'b0, 1'b0, 32, 3'b000, "to_wait1");
        applyStimulus(1'b0, 1'b0, 4,  3'b100, "to_rst2");
        applyStimulus(1'b0, 1'b0, 32, 3'b000, "to_wait2");
        applyStimulus(1'b0, 1'b0, 6,  3'b101, "to_fault");
        applyStimulus(1'b0, 1'b1, 1,  3'b100, "to_clear");
        applyStimulus(1'b0, 1'b0, 3,  3'b100, "to_rst3");
        applyStimulus(1'b0, 1'b0, 1,  3'b000, "to_wait3");

        // Stabilization glitch at STAB cycle 5, second glitch exhausts the retries.
        applyReset(1'b1);
        applyStimulus(1'b1, 1'b0, 3, 3'b100, "gl_rst");
        applyStimulus(1'b1, 1'b0, 5, 3'b000, "gl_wait_stab");
        applyStimulus(1'b0, 1'b0, 2, 3'b000, "gl_drop");
        applyStimulus(1'b1, 1'b0, 4, 3'b100, "gl_repulse");
        applyStimulus(1'b1, 1'b0, 3, 3'b000, "gl_wait2");
        applyStimulus(1'b0, 1'b0, 2, 3'b000, "gl_drop2");
        applyStimulus(1'b1, 1'b0, 5, 3'b101, "gl_fault");

        // Lock arrives in the last WAIT cycle; retry must still be zero afterwards.
        applyReset(1'b0);
        applyStimulus(1'b0, 1'b0, 3,  3'b100, "sim_rst");
        applyStimulus(1'b0, 1'b0, 30, 3'b000, "sim_wait");
        applyStimulus(1'b1, 1'b0, 3,  3'b000, "sim_lock_wins");
        applyStimulus(1'b0, 1'b0, 2,  3'b000, "sim_stab");
        applyStimulus(1'b0, 1'b0, 1,  3'b100, "sim_retry_kept");

        // Asynchronous reset in the middle of STAB.
        applyReset(1'b1);
        applyStimulus(1'b1, 1'b0, 3, 3'b100, "as_rst");
        applyStimulus(1'b1, 1'b0, 4, 3'b000, "as_stab");
        #2 rstn_i = 1'b0;
        #1 checkOutput("async_stab", {5'b0, pll_rst_o, lock_ok_o, fault_o}, 8'b100);

        // Randomized run against the model.
        applyReset(1'b0);
        modelOn = 1'b1;
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                locked_i = ($urandom_range(0, 2) != 0);
                hold     = $urandom_range(1, 45);
            end
            hold--;
            clr_fault_i = ($urandom_range(0, 19) == 0);
            tick();
            checkOutput($sformatf("rand[%0d] rst/ok/fault", c),
                        {5'b0, pll_rst_o, lock_ok_o, fault_o},
                        {5'b0, (mPh == PH_RST) || (mPh == PH_FAULT), mPh == PH_OK, mPh == PH_FAULT});
`ifdef PLL_LOCK_MON_STATS_EN
            checkOutput($sformatf("rand[%0d] loss_cnt", c), loss_cnt_o, 8'(mLosses));
`endif
        end
        modelOn     = 1'b0;
        clr_fault_i = 1'b0;

`ifdef PLL_LOCK_MON_STATS_EN
        // Loss counter saturation after 260 losses.
        applyReset(1'b1);
        for (int k = 0; k < 260; k++) begin
            waitLock($sformatf("sat_lock[%0d]", k));
            if (k == 100) checkOutput("loss_cnt_100", loss_cnt_o, 8'd100);
            locked_i = 1'b0;
            tick();
            locked_i = 1'b1;
            repeat (2) tick();
        end
        checkOutput("loss_cnt_sat", loss_cnt_o, 8'd255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
